axis_frame_arb: RTL and testbench

Two-source AXI-Stream frame arbiter and framer for the PAICORE datapath. It grants one 64-bit source at a time for a whole frame of software-programmed length, and regenerates `m_axis_tlast` on the final beat of each frame. It also reports per-source frame counts and input-`tlast` mismatches. It sits upstream of the DMA/frame path and lets two producers share one output stream.

---
 rtl/paicore_axis_pkg.sv | 13 +
 rtl/axis_frame_arb_rr_arb2.sv | 15 +
 rtl/axis_frame_arb.sv | 152 +++++++++++++++
 tb/tb_axis_frame_arb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/paicore_axis_pkg.sv
// Shared defaults and FSM state type for the PAICORE AXI-Stream framing blocks.
package paicore_axis_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_LEN_W  = 32;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/axis_frame_arb_rr_arb2.sv
// Two-requester round-robin picker; stateless, the parent holds last_grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt,
  output logic       valid
);

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb begin
    valid = |req;
    gnt   = (req == 2'b11) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/axis_frame_arb.sv
// Two-source AXI-Stream frame arbiter: grants one source per programmed-length
// frame, regenerates tlast, and counts frames and input-tlast mismatches.
module axis_frame_arb
  import paicore_axis_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_areset,
  input  logic              enable,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic [LEN_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  frame_cnt0,
  output logic [CNT_W-1:0]  frame_cnt1,
  output logic [CNT_W-1:0]  tlast_err
);

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   frame_cnt0_q, frame_cnt0_d;
  logic [CNT_W-1:0]   frame_cnt1_q, frame_cnt1_d;
  logic [CNT_W-1:0]   tlast_err_q, tlast_err_d;

  logic [1:0]         req;
  logic               arb_gnt;
  logic               arb_valid;
  logic               in_burst;
  logic [DATA_W-1:0]  sel_tdata;
  logic               sel_tvalid;
  logic               sel_tlast;
  logic               frame_end;
  logic               hs;

  always_comb begin
    req[0] = (len0 != '0) && s0_axis_tvalid;
    req[1] = (len1 != '0) && s1_axis_tvalid;
  end

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .valid      (arb_valid)
  );

  // Datapath is purely combinational; everything is gated off outside BURST.
  always_comb begin
    in_burst   = (state_q == ST_BURST);
    sel_tdata  = grant_q ? s1_axis_tdata  : s0_axis_tdata;
    sel_tvalid = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    sel_tlast  = grant_q ? s1_axis_tlast  : s0_axis_tlast;
    frame_end  = in_burst && (beat_cnt_q == (len_q - LEN_W'(1)));

    m_axis_tdata   = in_burst ? sel_tdata : '0;
    m_axis_tvalid  = in_burst && sel_tvalid;
    m_axis_tlast   = frame_end;
    m_axis_tid     = in_burst && grant_q;
    s0_axis_tready = in_burst && !grant_q && m_axis_tready;
    s1_axis_tready = in_burst &&  grant_q && m_axis_tready;
    hs             = m_axis_tvalid && m_axis_tready;

    busy       = in_burst;
    beat_cnt   = beat_cnt_q;
    frame_cnt0 = frame_cnt0_q;
    frame_cnt1 = frame_cnt1_q;
    tlast_err  = tlast_err_q;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    frame_cnt0_d = frame_cnt0_q;
    frame_cnt1_d = frame_cnt1_q;
    tlast_err_d  = tlast_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && arb_valid) begin
          state_d    = ST_BURST;
          grant_d    = arb_gnt;
          len_d      = arb_gnt ? len1 : len0;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if ((sel_tlast != frame_end) && (tlast_err_q != '1)) begin
            tlast_err_d = tlast_err_q + CNT_W'(1);
          end
          if (frame_end) begin
            state_d      = ST_IDLE;
            beat_cnt_d   = '0;
            last_grant_d = grant_q;
            if (grant_q) begin
              frame_cnt1_d = frame_cnt1_q + CNT_W'(1);
            end else begin
              frame_cnt0_d = frame_cnt0_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      frame_cnt0_q <= '0;
      frame_cnt1_q <= '0;
      tlast_err_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_cnt0_q <= frame_cnt0_d;
      frame_cnt1_q <= frame_cnt1_d;
      tlast_err_q  <= tlast_err_d;
    end
  end

endmodule

// File: tb/tb_axis_frame_arb.sv
// Randomized bench for axis_frame_arb, checked cycle by cycle against a
// frame-level reference model (remaining beats per open frame, round-robin by history).
module tb_axis_frame_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] len [2];
  logic [63:0] s_tdata [2];
  logic        s_tvalid [2];
  logic        s_tlast [2];
  logic        s0_tready, s1_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tid;
  logic        m_tready;
  logic        busy;
  logic [31:0] beat_cnt;
  logic [15:0] frame_cnt0, frame_cnt1, tlast_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_open;
  int          m_g;
  int unsigned m_remaining;
  int unsigned m_served;
  int          m_lastg;
  int unsigned m_fc [2];
  int unsigned m_err;
  bit          taken [2];

  always #5 clk = ~clk;

  axis_frame_arb dut (
    .s_axis_aclk    (clk),
    .s_axis_areset  (rst),
    .enable         (enable),
    .len0           (len[0]),
    .len1           (len[1]),
    .s0_axis_tdata  (s_tdata[0]),
    .s0_axis_tvalid (s_tvalid[0]),
    .s0_axis_tlast  (s_tlast[0]),
    .s0_axis_tready (s0_tready),
    .s1_axis_tdata  (s_tdata[1]),
    .s1_axis_tvalid (s_tvalid[1]),
    .s1_axis_tlast  (s_tlast[1]),
    .s1_axis_tready (s1_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tid     (m_tid),
    .m_axis_tready  (m_tready),
    .busy           (busy),
    .beat_cnt       (beat_cnt),
    .frame_cnt0     (frame_cnt0),
    .frame_cnt1     (frame_cnt1),
    .tlast_err      (tlast_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelReset();
    m_open      = 1'b0;
    m_g         = 0;
    m_remaining = 0;
    m_served    = 0;
    m_lastg     = 1;
    m_fc[0]     = 0;
    m_fc[1]     = 0;
    m_err       = 0;
    taken[0]    = 1'b0;
    taken[1]    = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void modelStep();
    bit e0, e1, last_beat;
    if (!m_open) begin
      e0 = (len[0] != 0) && s_tvalid[0];
      e1 = (len[1] != 0) && s_tvalid[1];
      if (enable && (e0 || e1)) begin
        if (e0 && e1) m_g = (m_lastg == 0) ? 1 : 0;
        else          m_g = e1 ? 1 : 0;
        m_open      = 1'b1;
        m_remaining = len[m_g];
        m_served    = 0;
      end
    end else if (s_tvalid[m_g] && m_tready) begin
      last_beat = (m_remaining == 1);
      if ((s_tlast[m_g] != last_beat) && (m_err < 32'hFFFF)) m_err++;
      taken[m_g] = 1'b1;
      m_served++;
      m_remaining--;
      if (m_remaining == 0) begin
        m_fc[m_g] = (m_fc[m_g] + 1) & 32'hFFFF;
        m_lastg   = m_g;
        m_open    = 1'b0;
        m_served  = 0;
      end
    end
  endfunction

  // Sources hold valid and data until their beat is accepted.
  task automatic applyStimulus(input int p_valid, input int p_ready, input int p_en,
                               input bit rdy_toggle, input int cyc, input bit do_rst);
    bit correct;
    rst = do_rst;
    for (int i = 0; i < 2; i++) begin
      if (!(s_tvalid[i] && !taken[i])) begin
        s_tdata[i]  = {$urandom(), $urandom()};
        s_tvalid[i] = ($urandom_range(0, 99) < p_valid);
      end
      taken[i] = 1'b0;
      if (m_open && m_g == i) begin
        correct    = (m_remaining == 1);
        s_tlast[i] = ($urandom_range(0, 9) == 0) ? !correct : correct;
      end else begin
        s_tlast[i] = ($urandom_range(0, 9) == 0);
      end
    end
    m_tready = rdy_toggle ? ~cyc[0] : ($urandom_range(0, 99) < p_ready);
    enable   = ($urandom_range(0, 99) < p_en);
  endtask

  task automatic checkAll();
    checkOutput("busy",      busy,       m_open);
    checkOutput("tvalid",    m_tvalid,   m_open && s_tvalid[m_g]);
    checkOutput("tdata",     m_tdata,    m_open ? s_tdata[m_g] : 64'd0);
    checkOutput("tlast",     m_tlast,    m_open && (m_remaining == 1));
    checkOutput("tid",       m_tid,      m_open ? m_g : 0);
    checkOutput("s0_tready", s0_tready,  m_open && m_g == 0 && m_tready);
    checkOutput("s1_tready", s1_tready,  m_open && m_g == 1 && m_tready);
    checkOutput("beat_cnt",  beat_cnt,   m_open ? m_served : 0);
    checkOutput("frame_cnt0", frame_cnt0, m_fc[0]);
    checkOutput("frame_cnt1", frame_cnt1, m_fc[1]);
    checkOutput("tlast_err", tlast_err,  m_err);
  endtask

  task automatic runCycle(input int p_valid, input int p_ready, input int p_en,
                          input bit rdy_toggle, input int cyc, input bit do_rst);
    applyStimulus(p_valid, p_ready, p_en, rdy_toggle, cyc, do_rst);
    #1;
    checkAll();
    @(posedge clk);
    if (do_rst) modelReset();
    else        modelStep();
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    m_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      len[i]      = 32'd0;
      s_tdata[i]  = 64'd0;
      s_tvalid[i] = 1'b0;
      s_tlast[i]  = 1'b0;
    end
    modelReset();
    @(posedge clk);
    @(negedge clk);

    // Contention: both always valid, alternating grants with an idle gap.
    len[0] = 32'd2;
    len[1] = 32'd3;
    for (int c = 0; c < 60; c++) runCycle(100, 100, 100, 1'b0, c, 1'b0);
    checkOutput("contention_fc0", frame_cnt0, m_fc[0]);

    // Backpressure with toggling sink ready, source 1 disabled by length.
    len[0] = 32'd3;
    len[1] = 32'd0;
    for (int c = 0; c < 80; c++) runCycle(80, 0, 100, 1'b1, c, 1'b0);

    // Single-beat frames on both sources.
    len[0] = 32'd1;
    len[1] = 32'd1;
    for (int c = 0; c < 60; c++) runCycle(70, 70, 100, 1'b0, c, 1'b0);

    // Fully random: lengths change at any time, enable drops, occasional reset.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) len[0] = $urandom_range(0, 6);
      if ($urandom_range(0, 19) == 0) len[1] = $urandom_range(0, 6);
      runCycle(70, 75, 90, 1'b0, c, $urandom_range(0, 249) == 0);
    end

    // Mid-frame reset followed by a clean restart.
    len[0] = 32'd6;
    len[1] = 32'd0;
    for (int c = 0; c < 4; c++) runCycle(100, 100, 100, 1'b0, c, 1'b0);
    runCycle(100, 100, 100, 1'b0, 0, 1'b1);
    for (int c = 0; c < 20; c++) runCycle(100, 100, 100, 1'b0, c, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
